// File: rtl/sub_iter.sv
// Iterative subtractor: a - b computed one 4-bit carry-lookahead slice per cycle, LSB first.
// Optional zero-result flag port enabled by defining SUB_ITER_ZERO_FLAG_EN.
module sub_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef SUB_ITER_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             ovf
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  nb_r;
    logic              carry_r;
    logic [IDX_W-1:0]  idx_r;
    logic [WIDTH-1:0]  diff_r;
    logic              bout_r;
    logic              ovf_r;
    logic              in_ready_r;
    logic              out_valid_r;
`ifdef SUB_ITER_ZERO_FLAG_EN
    logic              zero_r;
`endif

    logic [IDX_W+1:0]  off_s;
    logic [4:0]        slice_s;
    logic [WIDTH-1:0]  diff_next_s;

    // 4-bit carry-lookahead adder; returns {carry_out, sum}
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       co;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {co, p ^ c};
    endfunction

    // Current slice sum and the diff value it produces when written back
    always_comb begin
        off_s       = {idx_r, 2'b00};
        slice_s     = cla4(a_r[off_s +: 4], nb_r[off_s +: 4], carry_r);
        diff_next_s = diff_r;
        if (state_r == RUN) begin
            diff_next_s[off_s +: 4] = slice_s[3:0];
        end else begin
            diff_next_s = diff_r;
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= {WIDTH{1'b0}};
            nb_r        <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            idx_r       <= {IDX_W{1'b0}};
            diff_r      <= {WIDTH{1'b0}};
            bout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef SUB_ITER_ZERO_FLAG_EN
            zero_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r        <= a;
                        nb_r       <= ~b;
                        carry_r    <= 1'b1;
                        idx_r      <= {IDX_W{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    diff_r  <= diff_next_s;
                    carry_r <= slice_s[4];
                    idx_r   <= idx_r + 1'b1;
                    if (idx_r == LAST_IDX) begin
                        bout_r      <= ~slice_s[4];
                        // nb_r holds ~b, so its MSB is the inverse of b's sign
                        ovf_r       <= (a_r[WIDTH-1] == nb_r[WIDTH-1]) & (slice_s[3] != a_r[WIDTH-1]);
`ifdef SUB_ITER_ZERO_FLAG_EN
                        zero_r      <= (diff_next_s == {WIDTH{1'b0}});
`endif
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign bout      = bout_r;
    assign ovf       = ovf_r;
`ifdef SUB_ITER_ZERO_FLAG_EN
    assign zero      = zero_r;
`endif

endmodule

// File: doc/sub_iter.md
SUB_ITER -- requirements
Module: sub_iter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits; multiple of 4, minimum 8.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: in_valid  input  1  operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  block accepts operands.
REQ-006 SHALL have port: a  input  WIDTH  minuend.
REQ-007 SHALL have port: b  input  WIDTH  subtrahend.
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: diff  output  WIDTH  a minus b, modulo 2^WIDTH.
REQ-011 SHALL have port: bout  output  1  borrow out; 1 when unsigned a < b.
REQ-012 SHALL have port: ovf  output  1  two's-complement signed overflow.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE, drive in_ready=1 and out_valid=0; in RUN and DONE, drive in_ready=0.
REQ-015 SHALL, on the accepting edge (in_valid & in_ready), register a and ~b, set internal carry=1 and slice index=0, and enter RUN.
REQ-016 SHALL, on each RUN edge, compute one 4-bit slice {carry', s} = a_slice + ~b_slice + carry, using carry-lookahead generate/propagate logic, and write s into the diff register slice at the current index.
REQ-017 SHALL process slices LSB first and increment the slice index by 1 per RUN cycle.
REQ-018 SHALL remain in RUN for exactly N=WIDTH/4 cycles, then enter DONE; out_valid SHALL rise N cycles after the accepting edge.
REQ-019 SHALL set bout = ~carry after the final slice.
REQ-020 SHALL set ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the registered operands.
REQ-021 SHALL, in DONE, hold out_valid=1 and keep diff, bout and ovf stable until out_valid & out_ready.
REQ-022 SHALL return to IDLE on the edge where out_valid & out_ready; out_valid SHALL be 0 on the next cycle.
REQ-023 SHALL ignore in_valid outside IDLE; operands offered while the block is busy SHALL NOT be captured.
REQ-024 SHALL have no combinational path from any input to in_ready or out_valid.
REQ-025 SHALL keep diff, bout and ovf unchanged in IDLE (last result retained).

Reset
REQ-026 SHALL, on rst_n=0, immediately force state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, carry=0, slice index=0.
REQ-027 SHALL discard any in-flight operation when reset asserts mid-RUN or in DONE; no partial result SHALL be presented after reset.
REQ-028 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-029 SHALL, when macro SUB_ITER_ZERO_FLAG_EN is defined, provide extra port zero (output, 1 bit) equal to 1 iff diff==0; zero SHALL be reset to 0, be valid with out_valid, and hold with diff.
REQ-030 SHALL, when SUB_ITER_ZERO_FLAG_EN is undefined, omit port zero and all associated logic; all other behaviour SHALL be identical.

Verification
REQ-031 SHALL cover: a=0x00000005, b=0x00000003 -> diff=0x00000002, bout=0, ovf=0, out_valid exactly 8 cycles after accept.
REQ-032 SHALL cover: a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, bout=1, ovf=0.
REQ-033 SHALL cover: a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, bout=0, ovf=1.
REQ-034 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands driven -> diff, bout and ovf stable, in_ready=0, new operands not captured; result consumed on the first out_ready=1 cycle.
REQ-035 SHALL cover reset asserted in RUN cycle 4 -> all outputs take reset values immediately; a following op a=0x10, b=0x20 -> diff=0xFFFFFFF0, bout=1.
REQ-036 SHALL cover, with SUB_ITER_ZERO_FLAG_EN defined: a=b=0x00001234 -> diff=0, zero=1, bout=0; a=0x1235, b=0x1234 -> zero=0.
